// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix-keypad scanner.
package keypad_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Printed legend of each key, indexed by key code (row*4 + col).
  localparam logic [7:0] KEY_LEGEND [16] = '{
    "1", "2", "3", "A",
    "4", "5", "6", "B",
    "7", "8", "9", "C",
    "*", "0", "#", "D"
  };

  // Index of the lowest row pulled low; lower rows win when several are pressed.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// Dwell-end pulse generator: reloadable down-counter, same pattern as the
// display refresh divider. While disabled it sits at DIV-1 so that the next
// enabled period is always a full, fresh dwell.
module keypad_tick #(
  parameter logic [15:0] DIV = 16'd50000
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  output logic tick
);

  logic [15:0] cnt_reg;

  // Count down while enabled; reload on reset, when disabled, or after the last cycle.
  always_ff @(posedge clk) begin
    if (srst || !en || cnt_reg == 16'd0) begin
      cnt_reg <= DIV - 16'd1;
    end else begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

  assign tick = en && (cnt_reg == 16'd0);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix-keypad scanner: active-low column strobes, synchronized active-low
// rows, press/release debounce, 4-bit key code with a one-cycle valid strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter logic [15:0] CLK_DIV      = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000,
  parameter logic [23:0] REPEAT_DLY   = 24'd25000000,
  parameter logic [23:0] REPEAT_PER   = 24'd10000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  logic [3:0]  row_m_reg, row_s_reg;
  state_t      state_reg, state_next;
  logic [1:0]  col_idx_reg, col_idx_next;
  logic [3:0]  cap_reg, cap_next;
  logic [19:0] deb_cnt_reg, deb_cnt_next;
  logic [3:0]  key_reg, key_next;
  logic        key_valid_reg, key_valid_next;
  logic        key_held_reg, key_held_next;
  logic        dwell_tick;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [23:0] rep_cnt_reg, rep_cnt_next;
  logic        rep_first_reg, rep_first_next;
`endif

  keypad_tick #(.DIV(CLK_DIV)) u_tick (
    .clk  (CLK),
    .srst (RST),
    .en   (state_reg == SCAN),
    .tick (dwell_tick)
  );

  // Two-flop synchronizer for the asynchronous row lines; idles high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_m_reg <= 4'hF;
      row_s_reg <= 4'hF;
    end else begin
      row_m_reg <= row;
      row_s_reg <= row_m_reg;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= SCAN;
      col_idx_reg   <= 2'd0;
      cap_reg       <= 4'hF;
      deb_cnt_reg   <= 20'd0;
      key_reg       <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg   <= 24'd0;
      rep_first_reg <= 1'b1;
`endif
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      cap_reg       <= cap_next;
      deb_cnt_reg   <= deb_cnt_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
`endif
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    cap_next       = cap_reg;
    deb_cnt_next   = deb_cnt_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_next   = 24'd0;
    rep_first_next = rep_first_reg;
`endif
    case (state_reg)
      SCAN: begin
        if (dwell_tick) begin
          if (row_s_reg == 4'hF) begin
            col_idx_next = col_idx_reg + 2'd1;
          end else begin
            cap_next     = row_s_reg;
            deb_cnt_next = 20'd0;
            state_next   = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (row_s_reg == cap_reg) begin
          if (deb_cnt_reg == DEBOUNCE_CNT - 20'd1) begin
            key_next       = {low_row_idx(cap_reg), col_idx_reg};
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
            deb_cnt_next   = 20'd0;
            state_next     = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_first_next = 1'b1;
`endif
          end else begin
            deb_cnt_next = deb_cnt_reg + 20'd1;
          end
        end else begin
          col_idx_next = col_idx_reg + 2'd1;
          state_next   = SCAN;
        end
      end
      HELD: begin
        if (row_s_reg == 4'hF) begin
          deb_cnt_next = 20'd0;
          state_next   = RELEASE;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          // First repeat after REPEAT_DLY cycles, then one every REPEAT_PER.
          if (rep_first_reg && rep_cnt_reg == REPEAT_DLY - 24'd1) begin
            key_valid_next = 1'b1;
            rep_first_next = 1'b0;
          end else if (!rep_first_reg && rep_cnt_reg == REPEAT_PER - 24'd1) begin
            key_valid_next = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt_reg + 24'd1;
          end
`endif
        end
      end
      RELEASE: begin
        if (row_s_reg == 4'hF) begin
          if (deb_cnt_reg == DEBOUNCE_CNT - 20'd1) begin
            key_held_next = 1'b0;
            deb_cnt_next  = 20'd0;
            col_idx_next  = col_idx_reg + 2'd1;
            state_next    = SCAN;
          end else begin
            deb_cnt_next = deb_cnt_reg + 20'd1;
          end
        end else begin
          state_next = HELD;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign col       = ~(4'b0001 << col_idx_reg);
  assign key       = key_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule
